// File: rtl/operand_wait_queue.sv
// rtl/operand_wait_queue.sv - in-order operand wait queue with result-bus wakeup
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

module operand_wait_queue #(
    parameter int WORD_SIZE  = `WORD_SIZE,
    parameter int TAG_W      = `ROB_ENTRY_WIDTH,
    parameter int DEPTH      = 4,
    parameter int NUM_BYPASS = 3,
    parameter int PAYLOAD_W  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [TAG_W-1:0]                in_rob_id,
    input  logic [PAYLOAD_W-1:0]            in_payload,
    input  logic                            in_s1_valid,
    input  logic                            in_s2_valid,
    input  logic [WORD_SIZE-1:0]            in_s1_data,
    input  logic [WORD_SIZE-1:0]            in_s2_data,
    input  logic [NUM_BYPASS-1:0]           byp_valid,
    input  logic [NUM_BYPASS*TAG_W-1:0]     byp_rob_id,
    input  logic [NUM_BYPASS*WORD_SIZE-1:0] byp_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [TAG_W-1:0]                out_rob_id,
    output logic [PAYLOAD_W-1:0]            out_payload,
    output logic [WORD_SIZE-1:0]            out_s1_data,
    output logic [WORD_SIZE-1:0]            out_s2_data,
    input  logic                            flush,
    output logic [$clog2(DEPTH):0]          count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     s1_rdy_q, s1_rdy_d;
    logic [DEPTH-1:0]     s2_rdy_q, s2_rdy_d;
    logic [WORD_SIZE-1:0] s1_q [DEPTH];
    logic [WORD_SIZE-1:0] s1_d [DEPTH];
    logic [WORD_SIZE-1:0] s2_q [DEPTH];
    logic [WORD_SIZE-1:0] s2_d [DEPTH];
    logic [TAG_W-1:0]     rob_q [DEPTH];
    logic [TAG_W-1:0]     rob_d [DEPTH];
    logic [PAYLOAD_W-1:0] pay_q [DEPTH];
    logic [PAYLOAD_W-1:0] pay_d [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 do_enq, do_deq;

    // Search the broadcast channels for a tag; {hit, data}, lowest channel wins.
    function automatic logic [WORD_SIZE:0] wakeup(input logic [TAG_W-1:0] tag);
        logic [WORD_SIZE:0] r;
        r = '0;
        for (int c = NUM_BYPASS - 1; c >= 0; c--) begin
            if (byp_valid[c] && byp_rob_id[c*TAG_W +: TAG_W] == tag) begin
                r = {1'b1, byp_data[c*WORD_SIZE +: WORD_SIZE]};
            end
        end
        return r;
    endfunction

    assign in_ready    = (count_q != CNT_W'(DEPTH));
    assign out_valid   = valid_q[head_q] && s1_rdy_q[head_q] && s2_rdy_q[head_q];
    assign out_rob_id  = rob_q[head_q];
    assign out_payload = pay_q[head_q];
    assign out_s1_data = s1_q[head_q];
    assign out_s2_data = s2_q[head_q];
    assign count       = count_q;
    assign do_enq      = in_valid && in_ready && !flush;
    assign do_deq      = out_valid && out_ready && !flush;

    // Next state: wakeup of waiting operands, dequeue at head, enqueue at tail, flush last.
    always_comb begin
        logic [WORD_SIZE:0] w;
        valid_d  = valid_q;
        s1_rdy_d = s1_rdy_q;
        s2_rdy_d = s2_rdy_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        rob_d    = rob_q;
        pay_d    = pay_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
        w        = '0;

        for (int e = 0; e < DEPTH; e++) begin
            if (valid_q[e] && !s1_rdy_q[e]) begin
                w = wakeup(s1_q[e][TAG_W-1:0]);
                if (w[WORD_SIZE]) begin
                    s1_rdy_d[e] = 1'b1;
                    s1_d[e]     = w[WORD_SIZE-1:0];
                end
            end
            if (valid_q[e] && !s2_rdy_q[e]) begin
                w = wakeup(s2_q[e][TAG_W-1:0]);
                if (w[WORD_SIZE]) begin
                    s2_rdy_d[e] = 1'b1;
                    s2_d[e]     = w[WORD_SIZE-1:0];
                end
            end
        end

        if (do_deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        // The tail slot is never the slot being dequeued: enqueue needs a free slot.
        if (do_enq) begin
            valid_d[tail_q]  = 1'b1;
            rob_d[tail_q]    = in_rob_id;
            pay_d[tail_q]    = in_payload;
            s1_d[tail_q]     = in_s1_data;
            s1_rdy_d[tail_q] = in_s1_valid;
            s2_d[tail_q]     = in_s2_data;
            s2_rdy_d[tail_q] = in_s2_valid;
            if (!in_s1_valid) begin
                w = wakeup(in_s1_data[TAG_W-1:0]);
                if (w[WORD_SIZE]) begin
                    s1_rdy_d[tail_q] = 1'b1;
                    s1_d[tail_q]     = w[WORD_SIZE-1:0];
                end
            end
            if (!in_s2_valid) begin
                w = wakeup(in_s2_data[TAG_W-1:0]);
                if (w[WORD_SIZE]) begin
                    s2_rdy_d[tail_q] = 1'b1;
                    s2_d[tail_q]     = w[WORD_SIZE-1:0];
                end
            end
            tail_d = tail_q + 1'b1;
        end

        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                s1_q[e]  <= '0;
                s2_q[e]  <= '0;
                rob_q[e] <= '0;
                pay_q[e] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            s1_rdy_q <= s1_rdy_d;
            s2_rdy_q <= s2_rdy_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            rob_q    <= rob_d;
            pay_q    <= pay_d;
        end
    end

endmodule

// File: tb/tb_operand_wait_queue.sv
// tb/tb_operand_wait_queue.sv - directed table-driven bench for operand_wait_queue
module tb_operand_wait_queue;

    localparam int W     = 32;
    localparam int TW    = 6;
    localparam int DEPTH = 4;
    localparam int NB    = 3;
    localparam int PW    = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [TW-1:0]  in_rob_id = '0;
    logic [PW-1:0]  in_payload = '0;
    logic           in_s1_valid = 1'b0;
    logic           in_s2_valid = 1'b0;
    logic [W-1:0]   in_s1_data = '0;
    logic [W-1:0]   in_s2_data = '0;
    logic [NB-1:0]  byp_valid = '0;
    logic [NB*TW-1:0] byp_rob_id = '0;
    logic [NB*W-1:0]  byp_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [TW-1:0]  out_rob_id;
    logic [PW-1:0]  out_payload;
    logic [W-1:0]   out_s1_data;
    logic [W-1:0]   out_s2_data;
    logic           flush = 1'b0;
    logic [2:0]     count;

    int total = 0;
    int bad   = 0;

    operand_wait_queue #(
        .WORD_SIZE(W), .TAG_W(TW), .DEPTH(DEPTH), .NUM_BYPASS(NB), .PAYLOAD_W(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rob_id(in_rob_id),
        .in_payload(in_payload), .in_s1_valid(in_s1_valid), .in_s2_valid(in_s2_valid),
        .in_s1_data(in_s1_data), .in_s2_data(in_s2_data),
        .byp_valid(byp_valid), .byp_rob_id(byp_rob_id), .byp_data(byp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rob_id(out_rob_id),
        .out_payload(out_payload), .out_s1_data(out_s1_data), .out_s2_data(out_s2_data),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [TW-1:0] rob;
        logic          s1v;
        logic [W-1:0]  s1d;
        logic          s2v;
        logic [W-1:0]  s2d;
        logic          ordy;
        logic          fl;
        logic [NB-1:0] bv;
        logic [TW-1:0] bt0, bt1, bt2;
        logic [W-1:0]  bd0, bd1, bd2;
        logic          eov;
        int            ecnt;
        logic [TW-1:0] erob;
        logic [W-1:0]  es1;
        logic [W-1:0]  es2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic iv, input int rob, input logic s1v, input int s1d,
                                input logic s2v, input int s2d, input logic ordy, input logic fl,
                                input logic [NB-1:0] bv, input int bt0, input int bt1, input int bt2,
                                input int bd0, input int bd1, input int bd2,
                                input logic eov, input int ecnt, input int erob, input int es1, input int es2);
        vec_t v;
        v.iv = iv; v.rob = TW'(rob); v.s1v = s1v; v.s1d = W'(s1d); v.s2v = s2v; v.s2d = W'(s2d);
        v.ordy = ordy; v.fl = fl; v.bv = bv;
        v.bt0 = TW'(bt0); v.bt1 = TW'(bt1); v.bt2 = TW'(bt2);
        v.bd0 = W'(bd0); v.bd1 = W'(bd1); v.bd2 = W'(bd2);
        v.eov = eov; v.ecnt = ecnt; v.erob = TW'(erob); v.es1 = W'(es1); v.es2 = W'(es2);
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid    = v.iv;
        in_rob_id   = v.rob;
        in_payload  = {26'd0, v.rob};
        in_s1_valid = v.s1v;
        in_s1_data  = v.s1d;
        in_s2_valid = v.s2v;
        in_s2_data  = v.s2d;
        out_ready   = v.ordy;
        flush       = v.fl;
        byp_valid   = v.bv;
        byp_rob_id  = {v.bt2, v.bt1, v.bt0};
        byp_data    = {v.bd2, v.bd1, v.bd0};
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        chk({tag, ".count"}, W'(count), W'(v.ecnt));
        chk({tag, ".in_ready"}, W'(in_ready), W'(v.ecnt != DEPTH));
        chk({tag, ".out_valid"}, W'(out_valid), W'(v.eov));
        if (v.eov) begin
            chk({tag, ".out_rob_id"}, W'(out_rob_id), W'(v.erob));
            chk({tag, ".out_payload"}, out_payload, W'(v.erob));
            chk({tag, ".out_s1_data"}, out_s1_data, v.es1);
            chk({tag, ".out_s2_data"}, out_s2_data, v.es2);
        end
    endtask

    initial begin
        // Single-cycle transactions, wakeup, same-edge capture, priority.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 'h11, 1, 'h22, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 2, 'h11, 'h22));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 5, 1, 'h33, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 5, 0, 0, 'hABCD, 0, 1, 1, 3, 'hABCD, 'h33));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4, 0, 5, 1, 'h44, 0, 0, 3'b101, 5, 0, 5, 1, 0, 2, 1, 1, 4, 1, 'h44));
        tbl.push_back(mk(1, 5, 1, 'h55, 0, 7, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 2, 4, 1, 'h44));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b110, 0, 7, 7, 0, 'h70, 'h72, 1, 1, 5, 'h55, 'h70));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Fill to DEPTH with the output stalled.
        for (int k = 0; k < DEPTH; k++)
            tbl.push_back(mk(1, 8 + k, 1, 8 + k, 1, 'h108 + k, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0,
                             1, k + 1, 8, 8, 'h108));
        // Full: the offered enqueue is refused although a dequeue happens.
        tbl.push_back(mk(1, 12, 1, 12, 1, 'h10C, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 3, 9, 9, 'h109));
        // Eight enqueue/dequeue pairs wrap the pointers.
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1, 12 + k, 1, 12 + k, 1, 'h10C + k, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0,
                             1, 3, 10 + k, 10 + k, 'h10A + k));
        // Drain.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 2, 18, 18, 'h112));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 19, 19, 'h113));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Unready head blocks a ready younger entry, then flush beats enqueue.
        tbl.push_back(mk(1, 20, 0, 9, 1, 'h202, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 21, 1, 'h211, 1, 'h212, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 9, 0, 0, 'h99, 0, 0, 1, 2, 20, 'h99, 'h202));
        tbl.push_back(mk(1, 22, 1, 1, 1, 2, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state while rst is held low.
        #12;
        chk("reset.count", W'(count), 0);
        chk("reset.out_valid", W'(out_valid), 0);
        chk("reset.in_ready", W'(in_ready), 1);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_vec(i, tbl[i]);
        end

        // Asynchronous reset with three entries held.
        for (int k = 0; k < 3; k++) begin
            drive(mk(1, 30 + k, 1, 30 + k, 1, 'h130 + k, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("pre_rst.count", W'(count), 3);
        chk("pre_rst.out_valid", W'(out_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst.count", W'(count), 0);
        chk("async_rst.out_valid", W'(out_valid), 0);
        chk("async_rst.in_ready", W'(in_ready), 1);
        #1;
        rst = 1'b1;
        drive(mk(1, 40, 1, 'h400, 1, 'h401, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("post_rst.count", W'(count), 1);
        chk("post_rst.out_valid", W'(out_valid), 1);
        chk("post_rst.out_rob_id", W'(out_rob_id), 40);
        chk("post_rst.out_s1_data", out_s1_data, 'h400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_wait_queue.md
OPERAND_WAIT_QUEUE -- requirements
Module: operand_wait_queue

Interface
REQ-001 Parameter WORD_SIZE, default `WORD_SIZE (32): operand data width.
REQ-002 Parameter TAG_W, default `ROB_ENTRY_WIDTH: ROB id width, used for result tags.
REQ-003 Parameter DEPTH, default 4: number of entries; power of two, at least 2.
REQ-004 Parameter NUM_BYPASS, default 3: number of result broadcast channels (alu, mem, mul).
REQ-005 Parameter PAYLOAD_W, default 32: opaque decoded fields (funct3/funct7/opcode/imm/type).
REQ-006 clk, input, 1: the single clock.
REQ-007 rst, input, 1: reset, asynchronous and active-low.
REQ-008 in_valid, input, 1: enqueue request.
REQ-009 in_ready, output, 1: high when count < DEPTH.
REQ-010 in_rob_id, input, TAG_W: ROB id of the instruction.
REQ-011 in_payload, input, PAYLOAD_W: decoded fields.
REQ-012 in_s1_valid / in_s2_valid, input, 1 each: operand already resolved.
REQ-013 in_s1_data / in_s2_data, input, WORD_SIZE: operand value when the operand is resolved, otherwise the producer ROB tag in bits [TAG_W-1:0].
REQ-014 byp_valid, input, NUM_BYPASS: per-channel broadcast enable.
REQ-015 byp_rob_id, input, NUM_BYPASS*TAG_W: flattened tags, channel i at [i*TAG_W +: TAG_W].
REQ-016 byp_data, input, NUM_BYPASS*WORD_SIZE: flattened results.
REQ-017 out_valid, output, 1: head entry is ready to issue.
REQ-018 out_ready, input, 1: downstream accepts the instruction (not stalled).
REQ-019 out_rob_id / out_payload / out_s1_data / out_s2_data, output: head contents.
REQ-020 flush, input, 1: discard all entries (jump taken).
REQ-021 count, output, $clog2(DEPTH)+1: current occupancy.

Function
REQ-022 The queue is a circular FIFO with head and tail pointers that wrap modulo DEPTH; issue is strictly in order.
REQ-023 Enqueue occurs on a clock edge when in_valid && in_ready && !flush.
REQ-024 Each valid entry holds per-operand ready bits, plus a tag or data field for each operand.
REQ-025 On every edge, each valid entry's unready operand whose tag equals byp_rob_id[i] with byp_valid[i] high captures byp_data[i] and sets its ready bit.
REQ-026 If several channels match the same operand, the lowest channel index wins.
REQ-027 The capture rule of REQ-025 also applies to an unready operand being enqueued on the same edge, so there is no missed-wakeup window.
REQ-028 out_valid = head entry valid && s1 ready && s2 ready; it is a function of registered state only, so a capture becomes visible one cycle after the broadcast.
REQ-029 Dequeue occurs on an edge when out_valid && out_ready && !flush.
REQ-030 Simultaneous enqueue and dequeue leaves count unchanged.
REQ-031 When full, in_ready is low even if a dequeue happens in the same cycle.
REQ-032 When empty, out_valid is 0; an enqueued entry with both operands ready asserts out_valid on the following cycle (minimum latency 1).
REQ-033 A non-head entry that becomes ready waits until it reaches the head; there is no bypassing of older instructions.
REQ-034 On an edge with flush high, pointers and count go to 0 and all entries become invalid; flush has priority over enqueue and dequeue in that cycle.
REQ-035 out_* data outputs are don't-care when out_valid is 0.

Reset
REQ-036 While rst is low: count=0, head=tail=0, all entries invalid, out_valid=0, in_ready=1, asynchronously and independent of clk.
REQ-037 Reset asserted mid-operation discards all entries; the first edge after rst deasserts accepts an enqueue normally.

Verification
REQ-038 Enqueue rob 2, both operands ready (s1=0x11, s2=0x22) -> next cycle out_valid=1, out_s1_data=0x11, out_s2_data=0x22; out_ready=1 -> count returns to 0.
REQ-039 Enqueue rob 3 with s1 tag 5 unready; broadcast ch1 tag 5 data 0xABCD -> out_valid=0 that cycle, out_valid=1 with out_s1_data=0xABCD next cycle.
REQ-040 Broadcast tag 5 on the same edge as the enqueue of an entry waiting on tag 5; channels 0 and 2 both match with 0x1 and 0x2 -> captured 0x1, no hang.
REQ-041 Fill DEPTH=4 with out_ready=0 -> in_ready=0, count=4; then 8 enqueue/dequeue pairs -> pointers wrap, order preserved by rob id.
REQ-042 Head unready and entry 2 ready -> out_valid stays 0 until head captures; assert flush with in_valid=1 -> count=0 next cycle, nothing enqueued.
REQ-043 Pull rst low between edges with 3 entries held -> count=0 and out_valid=0 immediately, before the next clk edge.
